// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline stage buffer with freeze and flush; circular array of DEPTH entries.
// Optional PIPE_PERF_EN adds saturating stall_cycles/bubble_cycles counters.
module pipe_stage_buf #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             freeze,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      bubble_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    // Handshakes come from registered count only, so no ready path crosses stages.
    assign in_ready  = (count_q != CW'(DEPTH)) && !freeze;
    assign out_valid = (count_q != '0) && !freeze;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    // NOTE: every always_comb output gets its default first so no latch can be inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the payload array is deliberately not reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

`ifdef PIPE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] bubble_q;

    // Counters survive flush and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (out_ready && !out_valid && !freeze && (bubble_q != '1))
                bubble_q <= bubble_q + 32'd1;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: a DEPTH=2 and a DEPTH=4 instance, each with a data scoreboard.
// Define PIPE_PERF_EN for both RTL and bench to exercise the perf counters.
module tb_pipe_stage_buf;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DEPTH = 2 instance
    logic          flush, freeze, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [1:0]    count;
    // DEPTH = 4 instance
    logic          flush4, freeze4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [W-1:0]  in_data4, out_data4;
    logic [2:0]    count4;
`ifdef PIPE_PERF_EN
    logic [31:0]   stall2, bubble2, stall4, bubble4;
`endif

    pipe_stage_buf #(.WIDTH(W), .DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
`ifdef PIPE_PERF_EN
        , .stall_cycles(stall2), .bubble_cycles(bubble2)
`endif
    );

    pipe_stage_buf #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush4), .freeze(freeze4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .count(count4)
`ifdef PIPE_PERF_EN
        , .stall_cycles(stall4), .bubble_cycles(bubble4)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] sb4[$];
    logic acc4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle, score this cycle's transfers on both instances, then advance one edge.
    task automatic tick();
        logic [W-1:0] e;
        logic acc;
        #1;
        acc  = in_valid && in_ready && !flush;
        acc4 = in_valid4 && in_ready4 && !flush4;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) check("pop2_unexpected", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                check("pop2_data", 64'(out_data), 64'(e));
            end
        end
        if (out_valid4 && out_ready4) begin
            if (sb4.size() == 0) check("pop4_unexpected", 64'd1, 64'd0);
            else begin
                e = sb4.pop_front();
                check("pop4_data", 64'(out_data4), 64'(e));
            end
        end
        if (acc)    sb.push_back(in_data);
        if (acc4)   sb4.push_back(in_data4);
        if (flush)  sb.delete();
        if (flush4) sb4.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int guard;
        rst = 1'b1;
        flush = 0; freeze = 0; in_valid = 0; out_ready = 0; in_data = '0;
        flush4 = 0; freeze4 = 0; in_valid4 = 0; out_ready4 = 0; in_data4 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Mid-cycle asynchronous reset with one entry stored
        in_valid = 1; in_data = 32'h77;
        tick();
        in_valid = 0;
        check("pre_rst_count", 64'(count), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        #1;
        rst = 1'b0;

        // Streaming at one transfer per cycle
        out_ready = 1;
        in_valid = 1; in_data = 32'h1000;
        check("stream_in_ready0", 64'(in_ready), 64'd1);
        tick();
        in_data = 32'h1004;
        check("stream_count1", 64'(count), 64'd1);
        check("stream_in_ready1", 64'(in_ready), 64'd1);
        tick();
        in_data = 32'h1008;
        check("stream_count2", 64'(count), 64'd1);
        check("stream_in_ready2", 64'(in_ready), 64'd1);
        tick();
        in_valid = 0;
        check("stream_count3", 64'(count), 64'd1);
        tick();
        check("stream_drained", 64'(count), 64'd0);
        check("stream_out_valid", 64'(out_valid), 64'd0);

        // Fill and backpressure
        out_ready = 0;
        in_valid = 1; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        check("full_count", 64'(count), 64'd2);
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_data = 32'hC;
        tick();
        check("refused_count", 64'(count), 64'd2);
        out_ready = 1;
        #1;
        check("full_pop_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("bp_count_a", 64'(count), 64'd1);
        tick();
        in_valid = 0;
        check("bp_count_b", 64'(count), 64'd1);
        tick();
        check("bp_count_c", 64'(count), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Flush with a full buffer; the head pop is still seen downstream
        out_ready = 0;
        in_valid = 1; in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        in_data = 32'hD; flush = 1; out_ready = 1;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd1);
        tick();
        flush = 0; in_valid = 0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid_after", 64'(out_valid), 64'd0);
        // Flush drops a push even when in_ready is high
        out_ready = 0;
        in_valid = 1; in_data = 32'h31;
        tick();
        in_data = 32'hE; flush = 1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush = 0; in_valid = 0;
        tick();
        check("flush_drop_count", 64'(count), 64'd0);
        check("flush_drop_out_valid", 64'(out_valid), 64'd0);

        // Flush while frozen still clears
        in_valid = 1; in_data = 32'h41;
        tick();
        in_valid = 0; freeze = 1; flush = 1;
        tick();
        freeze = 0; flush = 0;
        check("flush_freeze_count", 64'(count), 64'd0);

        // Freeze holds contents and blocks both handshakes
        in_valid = 1; in_data = 32'h55;
        tick();
        freeze = 1; in_data = 32'h66; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("freeze_in_ready", 64'(in_ready), 64'd0);
            check("freeze_out_valid", 64'(out_valid), 64'd0);
            check("freeze_count", 64'(count), 64'd1);
            tick();
        end
        freeze = 0; in_valid = 0;
        #1;
        check("unfreeze_head", 64'(out_data), 64'h55);
        tick();
        check("unfreeze_count", 64'(count), 64'd0);
        out_ready = 0;

        // DEPTH = 4: fill, refused pushes, then streaming across pointer wrap
        in_valid4 = 1;
        for (int i = 0; i < 4; i++) begin
            in_data4 = 32'h200 + 32'(i);
            tick();
        end
        in_data4 = 32'h100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("d4_full_in_ready", 64'(in_ready4), 64'd0);
            tick();
        end
        check("d4_full_count", 64'(count4), 64'd4);
`ifdef PIPE_PERF_EN
        check("d4_stall_cycles", 64'(stall4), 64'd3);
`endif
        out_ready4 = 1;
        n = 0;
        guard = 0;
        while (n < 10 && guard < 40) begin
            in_data4 = 32'h100 + 32'(n);
            tick();
            if (acc4) n++;
            guard++;
        end
        check("d4_stream_done", 64'(n), 64'd10);
        check("d4_steady_count", 64'(count4), 64'd3);
        in_valid4 = 0;
        guard = 0;
        while (count4 != 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("d4_drained", 64'(count4), 64'd0);
        check("d4_sb_empty", 64'(sb4.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline stage buffer for the ARM five-stage core. It replaces the fixed freeze/flush stage registers between IF/ID/EXE/MEM/WB with a valid/ready FIFO of configurable width and depth, with freeze and flush control. With DEPTH ≥ 2 it sustains one transfer per cycle. Its in_ready depends only on registered state, so no combinational ready path crosses a stage boundary.

## Interface
- WIDTH, 32, payload bits per entry (pc, instruction, control bundle, etc.).
- DEPTH, 2, number of entries; power of two, ≥ 2.
- CW, $clog2(DEPTH+1), width of count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard all stored entries at next edge.
- freeze  in  1  hold contents; block push and pop.
- in_valid  in  1  upstream has data.
- in_ready  out  1  buffer accepts data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream accepts head.
- out_data  out  WIDTH  head payload.
- count  out  CW  entries currently stored.

## Operation
- Storage is a circular array of DEPTH entries, with wr_ptr and rd_ptr of width log2(DEPTH) that wrap modulo DEPTH.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH) && !freeze. It is independent of out_ready, so a push into a full buffer is never accepted even if a pop happens in the same cycle.
- out_valid = (count != 0) && !freeze.
- out_data = mem[rd_ptr]. It is undefined (don't-care) when out_valid = 0, and stable while out_valid && !out_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count = 1, the popped entry is the old head; the new entry becomes the head next cycle.
- Flush has priority over everything:
  - At the next edge, count, wr_ptr and rd_ptr go to 0.
  - A push presented in the flush cycle is dropped, even if in_ready = 1.
  - A pop in the flush cycle is still seen by downstream, because out_valid is not masked by flush.
- Flush during freeze still clears.
- Freeze: no pointer or count change. Contents are retained; both handshakes are deasserted.
- Reset mid-operation: state clears immediately, and the buffer behaves as just reset from the first edge after rst falls.
- The payload array is not reset; only pointers and count are reset.

## Timing
- Reset values:
  - in_ready = 1, unless freeze is high.
  - out_valid = 0.
  - count = 0.
  - out_data = don't-care.
- Latency: data pushed at edge N is on out_data with out_valid = 1 from edge N onward, i.e. visible in cycle N+1. The minimum pass-through is one cycle; there is no combinational in→out path.
- Throughput: one transfer per cycle in steady state with out_ready held high.
- Full boundary: at count = DEPTH, in_ready = 0 in the same cycle, driven from the registered count.
- Empty boundary: at count = 0, out_valid = 0.
- Freeze and flush are sampled synchronously; their effect on the handshakes is combinational in the same cycle.

## Configuration
- PIPE_PERF_EN: when defined, adds two output ports:
  - stall_cycles [31:0]: counts cycles with in_valid && !in_ready.
  - bubble_cycles [31:0]: counts cycles with out_ready && !out_valid && !freeze.
- Both counters saturate at 32'hFFFF_FFFF, reset to 0 on rst, and are not cleared by flush.
- When undefined, the ports and counters are absent and the block has no other behavioural difference.

## Test plan
- Reset then idle. Assert rst mid-cycle with no clock edge → out_valid = 0, count = 0, in_ready = 1 immediately.
- Streaming. With WIDTH = 32, DEPTH = 2 and out_ready = 1, push 0x1000, 0x1004, 0x1008 on consecutive cycles → out_data shows the same sequence one cycle later each, count stays at 1, and no in_ready drop occurs.
- Fill and backpressure. With out_ready = 0, push 0xA, 0xB:
  - count = 2 and in_ready = 0.
  - A third push of 0xC is refused.
  - Raising out_ready yields 0xA then 0xB, then 0xC after it is accepted.
- Flush priority. With count = 2, assert flush together with a valid push of 0xD → next cycle count = 0, out_valid = 0, and 0xD never appears.
- Freeze. With count = 1 holding 0x55, assert freeze for 3 cycles with in_valid = 1 and out_ready = 1 → in_ready = 0, out_valid = 0, count = 1 throughout; after release, 0x55 pops first.
- Wrap-around and perf counters. With DEPTH = 4, run 10 push/pop pairs → the sequence is preserved across pointer wrap. With PIPE_PERF_EN defined, 3 refused-push cycles give stall_cycles = 3.
